// File: rtl/usb_tx_line_encoder.sv
// USB full-speed transmit line encoder: bit stuffing, NRZI and EOP generation.
// Optional macro USB_TX_UNDERRUN_ABORT_EN truncates the packet on an upstream underrun.
module usb_tx_line_encoder (
    input  logic clk12_i,
    input  logic rst_i,
    input  logic txStart_i,
    input  logic data_i,
    input  logic dataValid_i,
    input  logic txLast_i,
    output logic dataReady_o,
    output logic dataP_o,
    output logic dataN_o,
    output logic outEn_o,
    output logic busy_o,
    output logic underrun_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DATA      = 3'd1,
        ST_STUFF     = 3'd2,
        ST_EOP_SE0_1 = 3'd3,
        ST_EOP_SE0_2 = 3'd4,
        ST_EOP_J     = 3'd5
    } state_t;

    state_t     state_r;
    logic [2:0] ones_cnt_r;
    logic [2:0] ones_inc_s;
    logic       level_r;
    logic       last_pend_r;
    logic       dp_r;
    logic       dn_r;
    logic       oe_r;
    logic       underrun_r;
    logic       take_s;
    logic       abort_s;

`ifdef USB_TX_UNDERRUN_ABORT_EN
    assign take_s  = dataValid_i;
    assign abort_s = ~dataValid_i;
`else
    // Upstream guarantees a bit every DATA cycle, so valid never gates acceptance.
    assign take_s  = dataValid_i | 1'b1;
    assign abort_s = 1'b0;
`endif

    assign ones_inc_s  = ones_cnt_r + 3'd1;
    assign dataReady_o = (state_r == ST_DATA) && !rst_i;
    assign busy_o      = (state_r != ST_IDLE);
    assign dataP_o     = dp_r;
    assign dataN_o     = dn_r;
    assign outEn_o     = oe_r;
    assign underrun_o  = underrun_r;

    // Packet FSM; line outputs show the symbol decided in the previous state.
    always_ff @(posedge clk12_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            ones_cnt_r  <= 3'd0;
            level_r     <= 1'b1;
            last_pend_r <= 1'b0;
            dp_r        <= 1'b1;
            dn_r        <= 1'b0;
            oe_r        <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    dp_r        <= 1'b1;
                    dn_r        <= 1'b0;
                    oe_r        <= 1'b0;
                    level_r     <= 1'b1;
                    ones_cnt_r  <= 3'd0;
                    last_pend_r <= 1'b0;
                    if (txStart_i) begin
                        state_r <= ST_DATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (abort_s) begin
                        underrun_r <= 1'b1;
                        state_r    <= ST_EOP_SE0_1;
                    end else if (take_s) begin
                        oe_r <= 1'b1;
                        if (data_i) begin
                            dp_r       <= level_r;
                            dn_r       <= ~level_r;
                            ones_cnt_r <= ones_inc_s;
                            // Sixth consecutive one: a stuffed zero must follow, even after the last bit.
                            if (ones_inc_s == 3'd6) begin
                                last_pend_r <= txLast_i;
                                state_r     <= ST_STUFF;
                            end else if (txLast_i) begin
                                state_r <= ST_EOP_SE0_1;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end else begin
                            level_r    <= ~level_r;
                            dp_r       <= ~level_r;
                            dn_r       <= level_r;
                            ones_cnt_r <= 3'd0;
                            if (txLast_i) begin
                                state_r <= ST_EOP_SE0_1;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_STUFF: begin
                    level_r     <= ~level_r;
                    dp_r        <= ~level_r;
                    dn_r        <= level_r;
                    oe_r        <= 1'b1;
                    ones_cnt_r  <= 3'd0;
                    last_pend_r <= 1'b0;
                    if (last_pend_r) begin
                        state_r <= ST_EOP_SE0_1;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_EOP_SE0_1: begin
                    dp_r    <= 1'b0;
                    dn_r    <= 1'b0;
                    oe_r    <= 1'b1;
                    state_r <= ST_EOP_SE0_2;
                end
                ST_EOP_SE0_2: begin
                    dp_r    <= 1'b0;
                    dn_r    <= 1'b0;
                    oe_r    <= 1'b1;
                    state_r <= ST_EOP_J;
                end
                ST_EOP_J: begin
                    dp_r    <= 1'b1;
                    dn_r    <= 1'b0;
                    oe_r    <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    dp_r       <= 1'b1;
                    dn_r       <= 1'b0;
                    oe_r       <= 1'b0;
                    level_r    <= 1'b1;
                    ones_cnt_r <= 3'd0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Self-checking bench for usb_tx_line_encoder: directed and random packets
// compared cycle by cycle against a stuffing/NRZI reference built from bit lists.
module tb_usb_tx_line_encoder;

    logic clk12_i = 1'b0;
    logic rst_i;
    logic txStart_i;
    logic data_i;
    logic dataValid_i;
    logic txLast_i;
    logic dataReady_o;
    logic dataP_o;
    logic dataN_o;
    logic outEn_o;
    logic busy_o;
    logic underrun_o;

    int total_r = 0;
    int bad_r   = 0;
    int pkt_no  = 0;
    bit pkt_q[$];

`ifdef USB_TX_UNDERRUN_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    always #5 clk12_i = ~clk12_i;

    usb_tx_line_encoder dut (
        .clk12_i     (clk12_i),
        .rst_i       (rst_i),
        .txStart_i   (txStart_i),
        .data_i      (data_i),
        .dataValid_i (dataValid_i),
        .txLast_i    (txLast_i),
        .dataReady_o (dataReady_o),
        .dataP_o     (dataP_o),
        .dataN_o     (dataN_o),
        .outEn_o     (outEn_o),
        .busy_o      (busy_o),
        .underrun_o  (underrun_o)
    );

    // Compared vector layout: {P, N, outEn, busy, ready, underrun}
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_r++;
        if (got !== exp) begin
            bad_r++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {dataP_o, dataN_o, outEn_o, busy_o, dataReady_o, underrun_o};
    endfunction

    // Sends pkt_q as one packet; caller is positioned just after a negedge with the DUT idle.
    task automatic run_packet(input bit rand_start, input bit rand_valid);
        bit sym_q[$];
        bit isdat_q[$];
        bit lvl_q[$];
        int ones;
        int n;
        int len;
        int idx;
        bit lvl;
        bit rdy_seen;
        logic [5:0] exp_v;
        n = pkt_q.size();
        ones = 0;
        foreach (pkt_q[i]) begin
            sym_q.push_back(pkt_q[i]);
            isdat_q.push_back(1'b1);
            ones = pkt_q[i] ? ones + 1 : 0;
            if (ones == 6) begin
                sym_q.push_back(1'b0);
                isdat_q.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 1'b1;
        foreach (sym_q[i]) begin
            if (!sym_q[i]) lvl = ~lvl;
            lvl_q.push_back(lvl);
        end
        len = sym_q.size();
        idx = 0;
        for (int c = 0; c < len + 6; c++) begin
            if (c <= 1)            exp_v[5:3] = 3'b100;
            else if (c <= len + 1) exp_v[5:3] = {lvl_q[c-2], ~lvl_q[c-2], 1'b1};
            else if (c <= len + 3) exp_v[5:3] = 3'b001;
            else if (c == len + 4) exp_v[5:3] = 3'b101;
            else                   exp_v[5:3] = 3'b100;
            exp_v[2] = (c >= 1) && (c <= len + 3);
            exp_v[1] = ((c >= 1) && (c <= len)) ? isdat_q[c-1] : 1'b0;
            exp_v[0] = 1'b0;
            check_eq($sformatf("pkt%0d.c%0d", pkt_no, c), {26'd0, outs()}, {26'd0, exp_v});
            rdy_seen = dataReady_o;
            if (c == 0)                   txStart_i = 1'b1;
            else if (c <= len + 3)        txStart_i = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
            else                          txStart_i = 1'b0;
            data_i      = pkt_q[(idx < n) ? idx : n - 1];
            txLast_i    = (idx == n - 1);
            dataValid_i = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk12_i);
            if (rdy_seen && idx < n) idx++;
        end
        txStart_i = 1'b0;
        pkt_no++;
    endtask

    initial begin
        rst_i       = 1'b1;
        txStart_i   = 1'b0;
        data_i      = 1'b0;
        dataValid_i = 1'b0;
        txLast_i    = 1'b0;
        repeat (3) @(negedge clk12_i);
        check_eq("reset", {26'd0, outs()}, {26'd0, 6'b100000});
        rst_i = 1'b0;
        @(negedge clk12_i);

        pkt_q = '{1'b0, 1'b1, 1'b0};
        run_packet(1'b0, 1'b0);
        pkt_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        run_packet(1'b0, 1'b0);
        pkt_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_packet(1'b0, 1'b0);
        pkt_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        run_packet(1'b1, 1'b0);

        // Reset held two cycles in the middle of a packet, with txStart also high.
        txStart_i = 1'b1;
        @(negedge clk12_i);
        txStart_i   = 1'b0;
        dataValid_i = 1'b1;
        data_i      = 1'b0;
        txLast_i    = 1'b0;
        repeat (3) @(negedge clk12_i);
        rst_i     = 1'b1;
        txStart_i = 1'b1;
        #1;
        check_eq("rst_ready", {31'd0, dataReady_o}, 32'd0);
        @(negedge clk12_i);
        @(negedge clk12_i);
        check_eq("rst_idle", {26'd0, outs()}, {26'd0, 6'b100000});
        rst_i     = 1'b0;
        txStart_i = 1'b0;
        @(negedge clk12_i);
        check_eq("rst_after", {26'd0, outs()}, {26'd0, 6'b100000});
        pkt_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_packet(1'b0, 1'b0);

        if (ABORT_EN) begin
            // Three accepted ones, then a missing bit.
            txStart_i   = 1'b1;
            dataValid_i = 1'b1;
            data_i      = 1'b1;
            txLast_i    = 1'b0;
            @(negedge clk12_i);
            txStart_i = 1'b0;
            repeat (3) @(negedge clk12_i);
            check_eq("ur_c4", {26'd0, outs()}, {26'd0, 6'b101110});
            dataValid_i = 1'b0;
            @(negedge clk12_i);
            check_eq("ur_pulse", {26'd0, outs()}, {26'd0, 6'b101101});
            dataValid_i = 1'b1;
            @(negedge clk12_i);
            check_eq("ur_se0a", {26'd0, outs()}, {26'd0, 6'b001100});
            @(negedge clk12_i);
            check_eq("ur_se0b", {26'd0, outs()}, {26'd0, 6'b001100});
            @(negedge clk12_i);
            check_eq("ur_j", {26'd0, outs()}, {26'd0, 6'b101000});
            @(negedge clk12_i);
            check_eq("ur_idle", {26'd0, outs()}, {26'd0, 6'b100000});
        end else begin
            pkt_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            run_packet(1'b0, 1'b1);
        end

        for (int t = 0; t < 40; t++) begin
            int n;
            pkt_q.delete();
            n = $urandom_range(1, 24);
            for (int b = 0; b < n; b++) pkt_q.push_back($urandom_range(0, 3) != 0);
            run_packet(1'($urandom_range(0, 1)), (!ABORT_EN) && ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(0, 2)) begin
                check_eq("gap", {26'd0, outs()}, {26'd0, 6'b100000});
                @(negedge clk12_i);
            end
        end

        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule

// File: doc/usb_tx_line_encoder.md
USB_TX_LINE_ENCODER -- requirements
Module: usb_tx_line_encoder

Interface
REQ-001 clk12_i  in  1  12 MHz bit clock; one line bit per cycle.
REQ-002 rst_i  in  1  reset, synchronous, active-high.
REQ-003 txStart_i  in  1  request to begin a packet; sampled only in IDLE.
REQ-004 data_i  in  1  raw (unstuffed, un-encoded) bit from upstream serializer, SYNC pattern included.
REQ-005 dataValid_i  in  1  data_i/txLast_i valid this cycle.
REQ-006 txLast_i  in  1  marks the accepted bit as the final packet bit.
REQ-007 dataReady_o  out  1  bit accepted this cycle when dataValid_i && dataReady_o.
REQ-008 dataP_o  out  1  D+ line level (registered).
REQ-009 dataN_o  out  1  D- line level (registered).
REQ-010 outEn_o  out  1  transceiver output enable (registered).
REQ-011 busy_o  out  1  high in every state except IDLE.
REQ-012 underrun_o  out  1  one-cycle pulse on upstream underrun.

Function
REQ-013 States SHALL be IDLE, DATA, STUFF, EOP_SE0_1, EOP_SE0_2, EOP_J.
REQ-014 IDLE: txStart_i=1 -> DATA next cycle; txStart_i ignored in all other states.
REQ-015 dataReady_o SHALL be combinationally 1 only in DATA, 0 otherwise (including STUFF).
REQ-016 A bit accepted in cycle N SHALL appear NRZI-encoded on dataP_o/dataN_o with outEn_o=1 in cycle N+1 (latency 1).
REQ-017 NRZI: bit 0 toggles the line level, bit 1 holds it; J = (P=1,N=0), K = (P=0,N=1); level register is J at packet start.
REQ-018 3-bit ones counter: +1 per transmitted 1, cleared by any transmitted 0 (data or stuffed), cleared on entering DATA from IDLE.
REQ-019 When an accepted 1 makes the counter 6, next state SHALL be STUFF; STUFF transmits a 0 (toggle), clears counter, returns to DATA, or to EOP_SE0_1 if the bit before it carried txLast_i.
REQ-020 Accepted bit with txLast_i=1 and no stuff pending -> EOP_SE0_1 next.
REQ-021 EOP_SE0_1, EOP_SE0_2: output P=0,N=0, outEn_o=1; EOP_J: output J, outEn_o=1, then IDLE.
REQ-022 IDLE output SHALL be J with outEn_o=0; busy_o=0.
REQ-023 Counter SHALL never exceed 6; STUFF is never skipped, including after the last bit.
REQ-024 DATA with dataValid_i=0 is an underrun; handling per REQ-029/030.

Reset
REQ-025 rst_i=1 SHALL force next-cycle state IDLE, ones counter 0, NRZI level J from any state, mid-packet included.
REQ-026 Reset values: dataP_o=1, dataN_o=0, outEn_o=0, busy_o=0, dataReady_o=0, underrun_o=0.
REQ-027 rst_i has priority over txStart_i and all handshakes in the same cycle.

Configuration
REQ-028 Macro USB_TX_UNDERRUN_ABORT_EN selects underrun handling.
REQ-029 Defined: underrun in DATA pulses underrun_o for that cycle, transmits no bit, and enters EOP_SE0_1 next (packet truncated, pending stuff dropped).
REQ-030 Not defined: underrun_o tied 0; in DATA data_i is transmitted every cycle regardless of dataValid_i (upstream guarantees validity).

Verification
REQ-031 Reset held 2 cycles mid-packet -> next cycle P=1,N=0, outEn_o=0, busy_o=0; new txStart_i starts cleanly from J.
REQ-032 txStart, bits 0,1,0(last) -> line K,K,J, then SE0,SE0,J with outEn_o=1, then outEn_o=0; busy_o high 6 cycles after start.
REQ-033 Bits 1x6 then 0(last) -> dataReady_o low exactly one cycle after sixth 1; line J x6, K (stuff), J, SE0,SE0,J.
REQ-034 Bits 1x6 with txLast_i on sixth -> stuffed K emitted before SE0; EOP unchanged.
REQ-035 With USB_TX_UNDERRUN_ABORT_EN: dataValid_i=0 after 3 bits -> underrun_o=1 one cycle, SE0 next cycle; without macro: underrun_o stays 0, data_i transmitted.
REQ-036 txStart_i pulsed during DATA and EOP_J -> ignored; no extra packet, IDLE reached on schedule.
